// File: rtl/iovec_ctrl_pkg.sv
// ============================================================================
// iovec_ctrl_pkg : shared types and constants for the IOBUF vector controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package iovec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_TURN  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } iovec_state_t;

`ifdef IOVEC_CTRL_SYNC_EN
  localparam int IOVEC_SYNC_STAGES = 2;
`else
  localparam int IOVEC_SYNC_STAGES = 0;
`endif

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iovec_sync.sv
// ============================================================================
// iovec_sync : per-bit 2-flop synchronizer, async active-low reset to 0
// Revision: 1.0
// ============================================================================
`default_nettype none

module iovec_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iovec_ctrl.sv
// ============================================================================
// iovec_ctrl : half-duplex request/response sequencer for an IOBUF vector.
// Option macro IOVEC_CTRL_SYNC_EN adds a 2-flop synchronizer on pin_O.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iovec_ctrl
  import iovec_ctrl_pkg::*;
#(
  parameter int IOVEC_WIDTH = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [IOVEC_WIDTH-1:0] req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IOVEC_WIDTH-1:0] rsp_data,
  output logic [IOVEC_WIDTH-1:0] pin_I,
  output logic                   pin_T,
  input  logic [IOVEC_WIDTH-1:0] pin_O
);

  localparam int CNT_MAX = max3(HOLD_CYCLES, TURN_CYCLES, IOVEC_SYNC_STAGES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counters load N-1 on entry and leave the state when they reach zero.
  localparam cnt_t HOLD_LOAD = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t TURN_LOAD = cnt_t'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam cnt_t SYNC_LOAD = cnt_t'((IOVEC_SYNC_STAGES > 0) ? IOVEC_SYNC_STAGES - 1 : 0);

  iovec_state_t           state, state_n;
  cnt_t                   cnt, cnt_n;
  logic [IOVEC_WIDTH-1:0] pin_i_n;
  logic [IOVEC_WIDTH-1:0] rsp_data_n;
  logic [IOVEC_WIDTH-1:0] sample;

`ifdef IOVEC_CTRL_SYNC_EN
  iovec_sync #(
    .WIDTH (IOVEC_WIDTH)
  ) u_sync (
    .clk   (CLK),
    .rst_n (nRST),
    .d     (pin_O),
    .q     (sample)
  );
`else
  assign sample = pin_O;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pin_i_n    = pin_I;
    rsp_data_n = rsp_data;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (req_write) begin
            state_n = ST_DRIVE;
            cnt_n   = HOLD_LOAD;
            pin_i_n = req_data;
          end else if (IOVEC_SYNC_STAGES == 0) begin
            state_n    = ST_RESP;
            rsp_data_n = sample;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = SYNC_LOAD;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
          if (TURN_CYCLES > 0) begin
            state_n = ST_TURN;
            cnt_n   = TURN_LOAD;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
      ST_TURN: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - cnt_t'(1);
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_n    = ST_RESP;
          rsp_data_n = sample;
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pin_I     <= '0;
      pin_T     <= 1'b1;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pin_I     <= pin_i_n;
      pin_T     <= (state_n != ST_DRIVE);
      req_ready <= (state_n == ST_IDLE);
      rsp_valid <= (state_n == ST_RESP);
      rsp_data  <= rsp_data_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iovec_ctrl.sv
// ============================================================================
// tb_iovec_ctrl : randomized bench for iovec_ctrl against a timeline model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iovec_ctrl;

  localparam int W   = 8;
  localparam int H   = 2;
  localparam int T   = 1;
  localparam int INF = 1 << 30;
`ifdef IOVEC_CTRL_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic         CLK = 1'b0;
  logic         nRST;
  logic         req_valid, req_write, rsp_ready;
  logic [W-1:0] req_data, pin_O;
  logic         req_ready, rsp_valid, pin_T;
  logic [W-1:0] rsp_data, pin_I;

  logic         b_req_valid, b_req_write, b_rsp_ready;
  logic [W-1:0] b_req_data, b_pin_O;
  logic         b_req_ready, b_rsp_valid, b_pin_T;
  logic [W-1:0] b_rsp_data, b_pin_I;

  iovec_ctrl #(.IOVEC_WIDTH(W), .HOLD_CYCLES(H), .TURN_CYCLES(T)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .pin_I(pin_I), .pin_T(pin_T), .pin_O(pin_O)
  );

  iovec_ctrl #(.IOVEC_WIDTH(W), .HOLD_CYCLES(2), .TURN_CYCLES(0)) dut_t0 (
    .CLK(CLK), .nRST(nRST),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write), .req_data(b_req_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .pin_I(b_pin_I), .pin_T(b_pin_T), .pin_O(b_pin_O)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Timeline model: edge indices at which each observable behaviour starts/stops.
  int       n;
  int       ready_at, ds, de, resp_at, resp_done;
  logic [W-1:0] i_old, i_new, d_old, d_new;

  function automatic logic m_ready();  return n >= ready_at; endfunction
  function automatic logic m_T();      return !(n >= ds && n < de); endfunction
  function automatic logic [W-1:0] m_I();    return (n >= ds) ? i_new : i_old; endfunction
  function automatic logic m_valid();  return (n >= resp_at) && (n < resp_done); endfunction
  function automatic logic [W-1:0] m_data(); return (n >= resp_at) ? d_new : d_old; endfunction
  function automatic logic rd_hold();  return (resp_at != INF) && (n < resp_at); endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    ready_at  = n + 1;
    ds        = INF;
    de        = INF;
    resp_at   = INF;
    resp_done = INF;
    i_old = '0; i_new = '0; d_old = '0; d_new = '0;
  endtask

  task automatic check_all();
    check("req_ready", {31'd0, req_ready}, {31'd0, m_ready()});
    check("pin_T",     {31'd0, pin_T},     {31'd0, m_T()});
    check("pin_I",     {24'd0, pin_I},     {24'd0, m_I()});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid()});
    check("rsp_data",  {24'd0, rsp_data},  {24'd0, m_data()});
  endtask

  task automatic step();
    @(posedge CLK);
    n++;
    #1;
  endtask

  // Present inputs for one cycle, advance the model, clock, then compare.
  task automatic cyc(input logic v, input logic w, input logic [W-1:0] d,
                     input logic rr, input logic [W-1:0] po);
    req_valid = v; req_write = w; req_data = d; rsp_ready = rr;
    if (!rd_hold()) pin_O = po;
    if (v && m_ready()) begin
      if (w) begin
        i_old = m_I(); i_new = d;
        ds = n + 1; de = n + 1 + H;
        ready_at = n + 1 + H + T;
      end else begin
        d_old = m_data(); d_new = pin_O;
        resp_at = n + 1 + S; resp_done = INF;
        ready_at = INF;
      end
    end
    if (m_valid() && rr) begin
      resp_done = n + 1;
      ready_at  = n + 1;
    end
    step();
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b0, '0, 1'b1, W'($urandom));
  endtask

  task automatic hold_reset_and_release();
    @(posedge CLK);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_T",     {31'd0, pin_T},     32'd1);
    check("rst_I",     {24'd0, pin_I},     32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  initial begin
    int lat;
    n = 0;
    nRST = 1'b0;
    req_valid = 0; req_write = 0; req_data = '0; rsp_ready = 0; pin_O = '0;
    b_req_valid = 0; b_req_write = 0; b_req_data = '0; b_rsp_ready = 1; b_pin_O = '0;
    #3;
    check("rst_data", {24'd0, rsp_data}, 32'd0);
    hold_reset_and_release();
    idle(1);

    // Directed: write 0xA5, read 0x3C with a stalled consumer, write then read.
    cyc(1'b1, 1'b1, 8'hA5, 1'b1, 8'h00);
    idle(4);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h3C);
    for (int i = 0; i < S + 5; i++) cyc(1'b0, 1'b0, '0, 1'b0, 8'h3C);
    cyc(1'b0, 1'b0, '0, 1'b1, 8'h3C);
    idle(1);
    cyc(1'b1, 1'b1, 8'hFF, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, '0, 1'b1, 8'h81);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) < 6, 1'($urandom), W'($urandom),
          $urandom_range(0, 3) != 0, W'($urandom));

    // Reset in the second DRIVE cycle releases the bus with no clock edge.
    for (int i = 0; i < 20 && !m_ready(); i++) cyc(1'b0, 1'b0, '0, 1'b1, '0);
    check("drain_ready", {31'd0, req_ready}, 32'd1);
    cyc(1'b1, 1'b1, 8'h6E, 1'b1, '0);
    cyc(1'b0, 1'b0, '0, 1'b1, '0);
    #2;
    nRST = 1'b0;
    #1;
    check("async_T", {31'd0, pin_T}, 32'd1);
    check("async_I", {24'd0, pin_I}, 32'd0);
    hold_reset_and_release();
    idle(3);

    // Reset while a response is pending discards it.
    cyc(1'b1, 1'b0, '0, 1'b0, 8'hC3);
    for (int i = 0; i < S + 2; i++) cyc(1'b0, 1'b0, '0, 1'b0, 8'hC3);
    check("pend_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    nRST = 1'b0;
    hold_reset_and_release();
    idle(2);

    // Second instance: TURN_CYCLES=0.
    check("t0_ready0", {31'd0, b_req_ready}, 32'd1);
    b_req_valid = 1; b_req_write = 1; b_req_data = 8'h5A;
    idle(1);
    b_req_valid = 0;
    check("t0_T_d1", {31'd0, b_pin_T}, 32'd0);
    check("t0_I",    {24'd0, b_pin_I}, 32'h5A);
    check("t0_rdy_d1", {31'd0, b_req_ready}, 32'd0);
    idle(1);
    check("t0_T_d2", {31'd0, b_pin_T}, 32'd0);
    idle(1);
    check("t0_T_end", {31'd0, b_pin_T}, 32'd1);
    check("t0_rdy_end", {31'd0, b_req_ready}, 32'd1);
    b_pin_O = 8'h96;
    b_req_valid = 1; b_req_write = 0;
    idle(1);
    b_req_valid = 0;
    lat = 1;
    while (!b_rsp_valid && lat < 10) begin
      idle(1);
      lat++;
    end
    check("t0_rd_lat", lat, S + 1);
    check("t0_rd_data", {24'd0, b_rsp_data}, 32'h96);
    check("t0_rdy_resp", {31'd0, b_req_ready}, 32'd0);
    idle(1);
    check("t0_rsp_done", {31'd0, b_rsp_valid}, 32'd0);
    check("t0_rdy_back", {31'd0, b_req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
